// File: rtl/z2_bus_master.sv
// z2_bus_master: 68020-style asynchronous bus-cycle initiator for the on-board
// DMA/IDE engine. It takes one request at a time, arbitrates for the local CPU
// bus (BR/BG/BGACK) and runs the cycle against a 16-bit port. Longwords are
// split into two word cycles by dynamic bus sizing. It then waits for TERM_N,
// and aborts with ERR if TERM_N does not arrive within TIMEOUT clocks.
//
// Ports:
//   CLKCPU, RESET          clock (rising edge), asynchronous active-low reset
//   REQ, REQ_RW, REQ_SIZE  request strobe, 1=read, size 01 byte/10 word/00 long
//   REQ_ADDR, REQ_WDATA    byte address, write data (right-justified)
//   BUSY, DONE, ERR, RDATA request status and read result
//   BR_N, BG_N, BGACK_N    bus arbitration
//   A, D, SIZ              address, 16-bit data, 68020 size code
//   AS20, DS20, RW20       strobes and direction (high-Z when not bus owner)
//   TERM_N, AS_IN          cycle termination, sensed AS of the current owner
module z2_bus_master #(
    parameter int TIMEOUT = 64,
    parameter int ADDR_W  = 24
) (
    input  logic              CLKCPU,
    input  logic              RESET,
    input  logic              REQ,
    input  logic              REQ_RW,
    input  logic [1:0]        REQ_SIZE,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    input  logic [31:0]       REQ_WDATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic [31:0]       RDATA,
    output logic              BR_N,
    input  logic              BG_N,
    output logic              BGACK_N,
    output logic [ADDR_W-1:0] A,
    inout  wire  [15:0]       D,
    output logic [1:0]        SIZ,
    output logic              AS20,
    output logic              DS20,
    output logic              RW20,
    input  logic              TERM_N,
    input  logic              AS_IN
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_OWN, S_ADDR, S_STROBE, S_WAIT, S_END, S_REL
    } state_t;

    state_t            state, state_n;
    logic              rw_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              second_q;
    logic              err_q;
    logic [31:0]       rdata_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              is_byte, is_word, is_long;
    logic              misalign;
    logic              timeout_hit;
    logic              more_half;
    logic              own, as_int, ds_int, d_drive;
    logic [1:0]        siz_int;
    logic [15:0]       wlane;

    assign is_byte  = (size_q == 2'b01);
    assign is_word  = (size_q == 2'b10);
    assign is_long  = !is_byte && !is_word;
    assign misalign = (REQ_SIZE != 2'b01) && REQ_ADDR[0];

    // The counter is cleared in STROBE and advances once per WAIT clock. Aborting
    // at TIMEOUT-3 places DONE (REL) exactly TIMEOUT clocks after STROBE:
    // STROBE, TIMEOUT-2 WAIT clocks, END, then REL. This requires TIMEOUT >= 3.
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 3));
    assign more_half   = is_long && !second_q && !err_q;

    always_ff @(posedge CLKCPU or negedge RESET) begin
        if (!RESET) begin
            state    <= S_IDLE;
            rw_q     <= 1'b1;
            size_q   <= 2'b01;
            addr_q   <= '0;
            wdata_q  <= '0;
            second_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state <= state_n;
            case (state)
                S_IDLE: begin
                    if (REQ) begin
                        rw_q     <= REQ_RW;
                        size_q   <= REQ_SIZE;
                        addr_q   <= REQ_ADDR;
                        wdata_q  <= REQ_WDATA;
                        second_q <= 1'b0;
                        err_q    <= misalign;
                    end
                end
                S_STROBE: cnt_q <= '0;
                S_WAIT: begin
                    if (!TERM_N) begin
                        if (rw_q) begin
                            if (is_byte)
                                rdata_q <= {24'h0, addr_q[0] ? D[7:0] : D[15:8]};
                            else if (is_word)
                                rdata_q <= {16'h0, D};
                            else if (second_q)
                                rdata_q <= {rdata_q[31:16], D};
                            else
                                rdata_q <= {D, 16'h0};
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (timeout_hit)
                            err_q <= 1'b1;
                    end
                end
                S_END: begin
                    if (more_half) begin
                        second_q <= 1'b1;
                        addr_q   <= addr_q + ADDR_W'(2);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (REQ) state_n = misalign ? S_REL : S_ARB;
            S_ARB:    if (!BG_N && AS_IN && TERM_N) state_n = S_OWN;
            S_OWN:    state_n = S_ADDR;
            S_ADDR:   state_n = S_STROBE;
            S_STROBE: state_n = S_WAIT;
            S_WAIT:   if (!TERM_N || timeout_hit) state_n = S_END;
            // END is the idle clock with AS high between the two longword halves.
            S_END:    state_n = more_half ? S_ADDR : S_REL;
            S_REL:    state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // Bus outputs decode straight from the state register, so the asynchronous
    // reset to IDLE releases the strobes and data bus without waiting for a clock.
    always_comb begin
        own     = (state inside {S_OWN, S_ADDR, S_STROBE, S_WAIT, S_END});
        as_int  = !(state inside {S_ADDR, S_STROBE, S_WAIT});
        ds_int  = !((state == S_ADDR && rw_q) || (state inside {S_STROBE, S_WAIT}));
        d_drive = !rw_q && (state inside {S_ADDR, S_STROBE, S_WAIT});
        siz_int = 2'b10;
        wlane   = wdata_q[15:0];
        if (is_byte) begin
            siz_int = 2'b01;
            wlane   = {wdata_q[7:0], wdata_q[7:0]};
        end else if (is_long && !second_q) begin
            siz_int = 2'b00;
            wlane   = wdata_q[31:16];
        end
    end

    assign BR_N    = (state != S_ARB);
    assign BGACK_N = !own;
    assign BUSY    = (state != S_IDLE);
    assign DONE    = (state == S_REL);
    assign ERR     = err_q;
    assign RDATA   = rdata_q;

    assign A    = own ? addr_q  : 'z;
    assign SIZ  = own ? siz_int : 'z;
    assign RW20 = own ? rw_q    : 1'bz;
    assign AS20 = own ? as_int  : 1'bz;
    assign DS20 = own ? ds_int  : 1'bz;
    assign D    = d_drive ? wlane : 'z;

endmodule

// File: doc/z2_bus_master.md
Name: z2_bus_master

Overview:
- Bus-cycle initiator that generates 68020-style asynchronous bus cycles (AS20/DS20/RW20/SIZ) on the local CPU bus.
- Issues one cycle per request from an on-board DMA/IDE engine, to fastmem, Zorro II or chip space.
- Arbitrates for the bus (BR/BG/BGACK), runs the cycle against a 16-bit port, and splits longword transfers by dynamic bus sizing.
- Waits for an active-low termination strobe, with timeout.

Parameters:
- TIMEOUT, 64, clocks from strobe assertion without termination before the cycle is aborted with error.
- ADDR_W, 24, address width.

Ports:
- CLKCPU  in  1  CPU clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- REQ  in  1  start request; sampled only in IDLE.
- REQ_RW  in  1  1=read, 0=write.
- REQ_SIZE  in  2  01 byte, 10 word, 00 long.
- REQ_ADDR  in  ADDR_W  byte address; word/long must be even.
- REQ_WDATA  in  32  write data; byte in [7:0], word in [15:0].
- BUSY  out  1  high from REQ acceptance until DONE.
- DONE  out  1  one-clock pulse at end of request.
- ERR  out  1  valid with DONE; 1 = timeout or misaligned.
- RDATA  out  32  read data, valid from DONE until next acceptance.
- BR_N  out  1  bus request.
- BG_N  in  1  bus grant.
- BGACK_N  out  1  bus grant acknowledge.
- A  out  ADDR_W  address; high-Z when not owner.
- D  inout  16  data; driven only during own write strobe phase.
- SIZ  out  2  68020 size code; high-Z when not owner.
- AS20  out  1  address strobe, active-low; high-Z when not owner.
- DS20  out  1  data strobe, active-low; high-Z when not owner.
- RW20  out  1  read/write; high-Z when not owner.
- TERM_N  in  1  cycle termination (DSACK/RAM_READY), active-low.
- AS_IN  in  1  sensed AS of the current owner (bus-free check).

Behaviour:
- Reset values: BR_N=1, BGACK_N=1, BUSY=0, DONE=0, ERR=0, RDATA=0, bus outputs high-Z, internal strobes=1, state IDLE.
- A reset mid-cycle returns to IDLE immediately; strobes released asynchronously.
- States: IDLE, ARB, OWN, ADDR, STROBE, WAIT, END, REL.
- IDLE:
  - REQ=1 latches REQ_*, sets BUSY=1.
  - If word/long with REQ_ADDR[0]=1: go to REL directly with ERR=1 and no bus activity.
  - Otherwise BR_N=0 and go to ARB.
- ARB: wait until BG_N=0 and AS_IN=1 and TERM_N=1, then BGACK_N=0, BR_N=1, go to OWN.
- OWN (1 clk): drive A, SIZ, RW20; AS20/DS20=1.
- ADDR (1 clk): AS20=0; reads also DS20=0. Writes drive D with the data lane:
  - byte: REQ_WDATA[7:0] on both halves.
  - word: [15:0].
  - long first half: [31:16]; second half: [15:0].
- STROBE (1 clk): writes DS20=0. Timeout counter cleared.
- WAIT:
  - TERM_N sampled each clock. On TERM_N=0, reads capture D:
    - byte: D[15:8] if A[0]=0, else D[7:0], into RDATA[7:0].
    - word: D into [15:0].
    - long: first half into [31:16], second into [15:0].
  - Then go to END.
  - Counter reaching TIMEOUT sets ERR=1 and goes to END.
- END:
  - Negate AS20/DS20, stop driving D.
  - If long, first half, and no error: SIZ=10, A=addr+2, back to ADDR after one idle clock with AS high.
  - Otherwise go to REL.
- REL: tristate bus outputs, BGACK_N=1, DONE=1 for one clock, BUSY=0, go to IDLE.
- SIZ codes driven:
  - byte=01, word=10.
  - long: 00 on first cycle, 10 on second.
- Address arithmetic wraps modulo 2^ADDR_W.
- REQ while BUSY is ignored.
- TERM_N already low at STROBE still completes normally: minimum cycle of 4 clocks after ownership.
- BG_N negated while waiting in ARB: keep BR_N low and keep waiting.
- BG_N negated once BGACK_N is asserted: ignored.

Test Plan:
- Word read at $200000: bus granted at clk 3, TERM_N low 2 clocks after AS20 -> SIZ=10, RW20=1, RDATA[15:0]=D=$BEEF, DONE pulse, ERR=0.
- Long write $12345678 to $400004 -> two cycles:
  - first: A=$400004, SIZ=00, D=$1234.
  - second: A=$400006, SIZ=10, D=$5678.
  - AS20 high at least 1 clock between them; DS20 asserted one clock after AS20 in each.
- Byte read at $E80003 with D=$A5C3 -> RDATA[7:0]=$C3; byte read at odd-free $E80002 -> $A5.
- No TERM_N, TIMEOUT=64 -> ERR=1 and DONE exactly 64 clocks after STROBE, strobes released, BGACK_N=1.
- Word request at odd address $200001 -> ERR=1, DONE, BR_N never asserted.
- RESET asserted during WAIT -> AS20/DS20/D released same cycle, BUSY=0; next REQ completes normally.
